i2c_config_slave: RTL

I2C_CONFIG_SLAVE -- requirements
Module: i2c_config_slave

---
 rtl/i2c_config_slave.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_config_slave.sv
// I2C register slave that holds the PWM configuration words (clock_step, fb_interval, run bit).
// Build option: define I2C_PTR_AUTOINC_EN to advance the register pointer after each data byte.
module i2c_config_slave #(
  parameter logic [6:0]  SLAVE_ADDR   = 7'h42,
  parameter logic [15:0] CLK_STEP_RST = 16'h0400,
  parameter logic [15:0] FB_INT_RST   = 16'd16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [15:0] clock_step,
  output logic [15:0] fb_interval,
  output logic        pwm_run
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  // Bit [1] is the synchronised level, bit [2] the previous sample for edge detection.
  logic [2:0]  sclSync_q, sdaSync_q;
  state_t      state_q, state_d;
  logic [3:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  ptr_q, ptr_d;
  logic        sdaOe_q, sdaOe_d;
  logic        isRead_q, isRead_d;
  logic        ackBit_q, ackBit_d;
  logic [15:0] clkStep_q, clkStep_d;
  logic [15:0] fbInt_q, fbInt_d;
  logic        run_q, run_d;
  logic [7:0]  csShadowL_q, csShadowL_d;
  logic [7:0]  fbShadowL_q, fbShadowL_d;
  logic [7:0]  csRdH_q, csRdH_d;
  logic [7:0]  fbRdH_q, fbRdH_d;
  logic        csRdValid_q, csRdValid_d;
  logic        fbRdValid_q, fbRdValid_d;

  logic       sclNow, sdaNow, sclRise, sclFall, startDet, stopDet;
  logic       loadTx, commit;
  logic [7:0] rdByte;
  logic [2:0] ptrNext;

  assign sclNow   = sclSync_q[1];
  assign sdaNow   = sdaSync_q[1];
  assign sclRise  = sclSync_q[1] & ~sclSync_q[2];
  assign sclFall  = ~sclSync_q[1] & sclSync_q[2];
  assign startDet = sclNow & sclSync_q[2] & ~sdaSync_q[1] & sdaSync_q[2];
  assign stopDet  = sclNow & sclSync_q[2] & sdaSync_q[1] & ~sdaSync_q[2];

`ifdef I2C_PTR_AUTOINC_EN
  assign ptrNext = ptr_q + 3'd1;
`else
  assign ptrNext = ptr_q;
`endif

  // H bytes return the snapshot taken by a preceding L read, so a 16-bit read is coherent.
  always_comb begin
    rdByte = 8'h00;
    case (ptr_q)
      3'd0:    rdByte = clkStep_q[7:0];
      3'd1:    rdByte = csRdValid_q ? csRdH_q : clkStep_q[15:8];
      3'd2:    rdByte = fbInt_q[7:0];
      3'd3:    rdByte = fbRdValid_q ? fbRdH_q : fbInt_q[15:8];
      3'd4:    rdByte = {7'd0, run_q};
      3'd7:    rdByte = 8'hA5;
      default: rdByte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sdaOe_d     = sdaOe_q;
    isRead_d    = isRead_q;
    ackBit_d    = ackBit_q;
    clkStep_d   = clkStep_q;
    fbInt_d     = fbInt_q;
    run_d       = run_q;
    csShadowL_d = csShadowL_q;
    fbShadowL_d = fbShadowL_q;
    csRdH_d     = csRdH_q;
    fbRdH_d     = fbRdH_q;
    csRdValid_d = csRdValid_q;
    fbRdValid_d = fbRdValid_q;
    loadTx      = 1'b0;
    commit      = 1'b0;

    case (state_q)
      IDLE, IGNORE: sdaOe_d = 1'b0;
      ADDR, PTR, WDATA: begin
        if (sclRise && bitCnt_q != 4'd8) begin
          shift_d  = {shift_q[6:0], sdaNow};
          bitCnt_d = bitCnt_q + 4'd1;
        end else if (sclFall && bitCnt_q == 4'd8) begin
          bitCnt_d = 4'd0;
          if (state_q == ADDR) begin
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d  = ADDR_ACK;
              sdaOe_d  = 1'b1;
              isRead_d = shift_q[0];
            end else begin
              state_d = IGNORE;
            end
          end else if (state_q == PTR) begin
            ptr_d   = shift_q[2:0];
            state_d = PTR_ACK;
            sdaOe_d = 1'b1;
          end else begin
            commit  = 1'b1;
            state_d = WDATA_ACK;
            sdaOe_d = 1'b1;
          end
        end
      end
      ADDR_ACK: begin
        if (sclFall) begin
          sdaOe_d = 1'b0;
          if (isRead_q) begin
            state_d = RDATA;
            loadTx  = 1'b1;
          end else begin
            state_d = PTR;
          end
        end
      end
      PTR_ACK, WDATA_ACK: begin
        if (sclFall) begin
          sdaOe_d = 1'b0;
          state_d = WDATA;
        end
      end
      RDATA: begin
        if (sclRise && bitCnt_q != 4'd8) begin
          bitCnt_d = bitCnt_q + 4'd1;
        end else if (sclFall && bitCnt_q == 4'd8) begin
          state_d  = RACK;
          sdaOe_d  = 1'b0;
          bitCnt_d = 4'd0;
          ptr_d    = ptrNext;
        end else if (sclFall && bitCnt_q != 4'd0) begin
          sdaOe_d = ~shift_q[6];
          shift_d = {shift_q[6:0], 1'b0};
        end
      end
      RACK: begin
        if (sclRise) begin
          ackBit_d = sdaNow;
          bitCnt_d = 4'd1;
        end else if (sclFall && bitCnt_q == 4'd1) begin
          bitCnt_d = 4'd0;
          if (!ackBit_q) begin
            state_d = RDATA;
            loadTx  = 1'b1;
          end else begin
            state_d = IGNORE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // L bytes only reach the outputs together with their H byte.
    if (commit) begin
      case (ptr_q)
        3'd0:    csShadowL_d = shift_q;
        3'd1:    clkStep_d   = {shift_q, csShadowL_q};
        3'd2:    fbShadowL_d = shift_q;
        3'd3:    fbInt_d     = {shift_q, fbShadowL_q};
        3'd4:    run_d       = shift_q[0];
        default: ;
      endcase
      ptr_d = ptrNext;
    end

    if (loadTx) begin
      shift_d = rdByte;
      sdaOe_d = ~rdByte[7];
      case (ptr_q)
        3'd0: begin csRdH_d = clkStep_q[15:8]; csRdValid_d = 1'b1; end
        3'd1: csRdValid_d = 1'b0;
        3'd2: begin fbRdH_d = fbInt_q[15:8]; fbRdValid_d = 1'b1; end
        3'd3: fbRdValid_d = 1'b0;
        default: ;
      endcase
    end

    if (startDet) begin
      state_d  = ADDR;
      bitCnt_d = 4'd0;
      sdaOe_d  = 1'b0;
    end else if (stopDet) begin
      state_d = IDLE;
      sdaOe_d = 1'b0;
    end
  end

  // Synchronisers reset to the idle bus level so release of reset cannot fake a START.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclSync_q   <= 3'b111;
      sdaSync_q   <= 3'b111;
      state_q     <= IDLE;
      bitCnt_q    <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 3'd0;
      sdaOe_q     <= 1'b0;
      isRead_q    <= 1'b0;
      ackBit_q    <= 1'b1;
      clkStep_q   <= CLK_STEP_RST;
      fbInt_q     <= FB_INT_RST;
      run_q       <= 1'b0;
      csShadowL_q <= 8'h00;
      fbShadowL_q <= 8'h00;
      csRdH_q     <= 8'h00;
      fbRdH_q     <= 8'h00;
      csRdValid_q <= 1'b0;
      fbRdValid_q <= 1'b0;
    end else begin
      sclSync_q   <= {sclSync_q[1:0], scl};
      sdaSync_q   <= {sdaSync_q[1:0], sda_in};
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sdaOe_q     <= sdaOe_d;
      isRead_q    <= isRead_d;
      ackBit_q    <= ackBit_d;
      clkStep_q   <= clkStep_d;
      fbInt_q     <= fbInt_d;
      run_q       <= run_d;
      csShadowL_q <= csShadowL_d;
      fbShadowL_q <= fbShadowL_d;
      csRdH_q     <= csRdH_d;
      fbRdH_q     <= fbRdH_d;
      csRdValid_q <= csRdValid_d;
      fbRdValid_q <= fbRdValid_d;
    end
  end

  assign sda_oe      = sdaOe_q;
  assign clock_step  = clkStep_q;
  assign fb_interval = fbInt_q;
  assign pwm_run     = run_q;

endmodule
